// File: rtl/qdma_c2h_cmp_order_buf_if.sv
`default_nettype none
// ============================================================================
// Module : qdma_c2h_cmp_order_buf_if
// Brief  : C2H payload/completion streams in and out of the ordering buffer
// Rev    : 1.0
// ============================================================================
interface qdma_c2h_cmp_order_buf_if #(
  parameter int MAX_DATA_WIDTH = 512,
  parameter int CTRL_WIDTH     = 64,
  parameter int CMP_WIDTH      = 128
);
  localparam int MTY_W = $clog2(MAX_DATA_WIDTH/8);

  logic [MAX_DATA_WIDTH-1:0] in_pld_tdata;
  logic [CTRL_WIDTH-1:0]     in_pld_ctrl;
  logic [MTY_W-1:0]          in_pld_mty;
  logic                      in_pld_tlast;
  logic                      in_pld_tvalid;
  logic                      in_pld_tready;
  logic [CMP_WIDTH-1:0]      in_cmp_data;
  logic                      in_cmp_tvalid;
  logic                      in_cmp_tready;

  logic [MAX_DATA_WIDTH-1:0] out_pld_tdata;
  logic [CTRL_WIDTH-1:0]     out_pld_ctrl;
  logic [MTY_W-1:0]          out_pld_mty;
  logic                      out_pld_tlast;
  logic                      out_pld_tvalid;
  logic                      out_pld_tready;
  logic [CMP_WIDTH-1:0]      out_cmp_data;
  logic                      out_cmp_tlast;
  logic                      out_cmp_tvalid;
  logic                      out_cmp_tready;

  modport slave (
    input  in_pld_tdata, in_pld_ctrl, in_pld_mty, in_pld_tlast, in_pld_tvalid,
    output in_pld_tready,
    input  in_cmp_data, in_cmp_tvalid,
    output in_cmp_tready,
    output out_pld_tdata, out_pld_ctrl, out_pld_mty, out_pld_tlast, out_pld_tvalid,
    input  out_pld_tready,
    output out_cmp_data, out_cmp_tlast, out_cmp_tvalid,
    input  out_cmp_tready
  );

  modport master (
    output in_pld_tdata, in_pld_ctrl, in_pld_mty, in_pld_tlast, in_pld_tvalid,
    input  in_pld_tready,
    output in_cmp_data, in_cmp_tvalid,
    input  in_cmp_tready,
    input  out_pld_tdata, out_pld_ctrl, out_pld_mty, out_pld_tlast, out_pld_tvalid,
    output out_pld_tready,
    input  out_cmp_data, out_cmp_tlast, out_cmp_tvalid,
    output out_cmp_tready
  );
endinterface
`default_nettype wire

// File: rtl/qdma_c2h_cmp_order_buf.sv
`default_nettype none
// ============================================================================
// Module : qdma_c2h_cmp_order_buf
// Brief  : Holds each C2H completion until its payload tlast beat has left;
//          statistics counters built only with QDMA_C2H_ORD_STATS_EN.
// Rev    : 1.0
// ============================================================================
module qdma_c2h_cmp_order_buf #(
  parameter int MAX_DATA_WIDTH = 512,
  parameter int CTRL_WIDTH     = 64,
  parameter int CMP_WIDTH      = 128,
  parameter int PLD_FIFO_DEPTH = 16,
  parameter int CMP_FIFO_DEPTH = 8,
  parameter int TCQ            = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  qdma_c2h_cmp_order_buf_if.slave           c2h,
  output logic [$clog2(PLD_FIFO_DEPTH):0]   pld_fifo_level,
  output logic [31:0]                       stat_pkt_cnt,
  output logic [31:0]                       stat_cmp_cnt
);
  localparam int MTY_W = $clog2(MAX_DATA_WIDTH/8);
  localparam int PAW   = $clog2(PLD_FIFO_DEPTH);
  localparam int CAW   = $clog2(CMP_FIFO_DEPTH);
  localparam int PW    = MAX_DATA_WIDTH + CTRL_WIDTH + MTY_W + 1;
  localparam int RW    = PAW + 2;
  localparam logic [PAW:0]  PLD_FULL = (PAW+1)'(PLD_FIFO_DEPTH);
  localparam logic [CAW:0]  CMP_FULL = (CAW+1)'(CMP_FIFO_DEPTH);
  localparam logic [RW-1:0] RDY_MAX  = '1;

  // Register delays are not modelled in synthesizable RTL; TCQ is accepted only.
  if (TCQ != 0) begin : g_tcq_ignored
  end

  logic [PW-1:0]        pld_mem_q [PLD_FIFO_DEPTH];
  logic [PAW:0]         pld_wptr_q, pld_rptr_q, pld_wptr_d, pld_rptr_d, pld_lvl_d;
  logic                 pld_rdy_q, pld_wr, pld_rd, pld_empty, pld_gate;
  logic [PW-1:0]        pld_head;

  logic [CMP_WIDTH-1:0] cmp_mem_q [CMP_FIFO_DEPTH];
  logic [CAW:0]         cmp_wptr_q, cmp_rptr_q, cmp_wptr_d, cmp_rptr_d, cmp_lvl_d;
  logic                 cmp_rdy_q, cmp_wr, cmp_rd, cmp_empty;

  logic [RW-1:0]        pkt_rdy_q, pkt_rdy_d;
  logic                 rel_inc, rel_dec;

  // Payload FIFO (first-word-fall-through)
  assign pld_empty  = (pld_wptr_q == pld_rptr_q);
  assign pld_head   = pld_mem_q[pld_rptr_q[PAW-1:0]];
  assign pld_gate   = pld_head[0] && (pkt_rdy_q == RDY_MAX);
  assign pld_wr     = c2h.in_pld_tvalid && pld_rdy_q;
  assign pld_rd     = c2h.out_pld_tvalid && c2h.out_pld_tready;
  assign pld_wptr_d = pld_wptr_q + (PAW+1)'(pld_wr);
  assign pld_rptr_d = pld_rptr_q + (PAW+1)'(pld_rd);
  assign pld_lvl_d  = pld_wptr_d - pld_rptr_d;

  assign c2h.in_pld_tready  = pld_rdy_q;
  assign c2h.out_pld_tvalid = !pld_empty && !pld_gate;
  assign {c2h.out_pld_tdata, c2h.out_pld_ctrl, c2h.out_pld_mty, c2h.out_pld_tlast} = pld_head;
  assign pld_fifo_level     = pld_wptr_q - pld_rptr_q;

  always_ff @(posedge clk) begin
    if (pld_wr) begin
      pld_mem_q[pld_wptr_q[PAW-1:0]] <= {c2h.in_pld_tdata, c2h.in_pld_ctrl,
                                         c2h.in_pld_mty, c2h.in_pld_tlast};
    end
  end

  // Completion FIFO
  assign cmp_empty  = (cmp_wptr_q == cmp_rptr_q);
  assign cmp_wr     = c2h.in_cmp_tvalid && cmp_rdy_q;
  assign cmp_rd     = c2h.out_cmp_tvalid && c2h.out_cmp_tready;
  assign cmp_wptr_d = cmp_wptr_q + (CAW+1)'(cmp_wr);
  assign cmp_rptr_d = cmp_rptr_q + (CAW+1)'(cmp_rd);
  assign cmp_lvl_d  = cmp_wptr_d - cmp_rptr_d;

  assign c2h.in_cmp_tready  = cmp_rdy_q;
  assign c2h.out_cmp_tvalid = !cmp_empty && (pkt_rdy_q != '0);
  assign c2h.out_cmp_data   = cmp_mem_q[cmp_rptr_q[CAW-1:0]];
  assign c2h.out_cmp_tlast  = 1'b1;

  always_ff @(posedge clk) begin
    if (cmp_wr) begin
      cmp_mem_q[cmp_wptr_q[CAW-1:0]] <= c2h.in_cmp_data;
    end
  end

  // Released-packet credit: one per departed tlast beat, spent by each completion.
  assign rel_inc = pld_rd && pld_head[0];
  assign rel_dec = cmp_rd;

  always_comb begin
    pkt_rdy_d = pkt_rdy_q;
    if (rel_inc && !rel_dec) begin
      pkt_rdy_d = pkt_rdy_q + RW'(1);
    end else if (!rel_inc && rel_dec) begin
      pkt_rdy_d = pkt_rdy_q - RW'(1);
    end
  end

  // Ready flags are registered from next-cycle fullness so a full FIFO never takes a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pld_wptr_q <= '0;
      pld_rptr_q <= '0;
      pld_rdy_q  <= 1'b0;
      cmp_wptr_q <= '0;
      cmp_rptr_q <= '0;
      cmp_rdy_q  <= 1'b0;
      pkt_rdy_q  <= '0;
    end else begin
      pld_wptr_q <= pld_wptr_d;
      pld_rptr_q <= pld_rptr_d;
      pld_rdy_q  <= (pld_lvl_d != PLD_FULL);
      cmp_wptr_q <= cmp_wptr_d;
      cmp_rptr_q <= cmp_rptr_d;
      cmp_rdy_q  <= (cmp_lvl_d != CMP_FULL);
      pkt_rdy_q  <= pkt_rdy_d;
    end
  end

`ifdef QDMA_C2H_ORD_STATS_EN
  logic [31:0] stat_pkt_q, stat_cmp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt_q <= '0;
      stat_cmp_q <= '0;
    end else begin
      stat_pkt_q <= stat_pkt_q + 32'(rel_inc);
      stat_cmp_q <= stat_cmp_q + 32'(rel_dec);
    end
  end

  assign stat_pkt_cnt = stat_pkt_q;
  assign stat_cmp_cnt = stat_cmp_q;
`else
  assign stat_pkt_cnt = '0;
  assign stat_cmp_cnt = '0;
`endif

endmodule
`default_nettype wire
